// File: rtl/cb_inreq.sv
// Input-port requester: round-robin picks a VC head, requests the crossbar, streams the packet wormhole-style.
// Latency: eligible head at t -> req at t+1 -> flit on idata at t+2 (grant/credit seen at t+1); one flit/cycle.
// Backpressure: a flit moves only when grant, buffer-valid and downstream credit coincide; otherwise req holds.
//
// Ports:
//   clk, rst_                        clock, asynchronous active-low reset
//   vc_valid/vc_data/vc_head/
//   vc_tail/vc_port                  per-VC buffer head flit and its routing info
//   vc_deq                           one-hot combinational pop of the selected VC buffer
//   cr_ok                            per-output-port downstream credit available
//   req, port                        registered crossbar request and requested output port
//   grt                              crossbar grant vector (only bit `port` matters)
//   idata, ivalid, ivch              registered flit onto the crossbar input
//   err                              sticky flag: a head flit asked for a nonexistent port
module cb_inreq #(
    parameter int DATA_W = 64,
    parameter int VCN    = 2,
    parameter int VCHW   = 1,
    parameter int PORT_N = 5,
    parameter int PORTW  = 3
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [VCN-1:0]        vc_valid,
    input  logic [VCN*DATA_W-1:0] vc_data,
    input  logic [VCN-1:0]        vc_head,
    input  logic [VCN-1:0]        vc_tail,
    input  logic [VCN*PORTW-1:0]  vc_port,
    output logic [VCN-1:0]        vc_deq,
    input  logic [PORT_N-1:0]     cr_ok,
    output logic                  req,
    output logic [PORTW-1:0]      port,
    input  logic [PORT_N-1:0]     grt,
    output logic [DATA_W-1:0]     idata,
    output logic                  ivalid,
    output logic [VCHW-1:0]       ivch,
    output logic                  err
);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    // One extra bit so the bound still compares correctly when PORT_N == 2**PORTW.
    localparam logic [PORTW:0] PORT_LIM = (PORTW+1)'(PORT_N);

    state_t              state_q, state_d;
    logic [VCHW-1:0]     sel_vc_q, sel_vc_d;
    logic [PORTW-1:0]    sel_port_q, sel_port_d;
    logic [VCHW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   idata_q;
    logic                ivalid_q;
    logic [VCHW-1:0]     ivch_q;
    logic                err_q;

    logic [DATA_W-1:0]   data_a [VCN];
    logic [PORTW-1:0]    port_a [VCN];
    logic [VCN-1:0]      elig;
    logic [VCN-1:0]      bad_head;
    logic                found;
    logic [VCHW-1:0]     win;
    logic [VCHW-1:0]     cand;
    logic                xfer;

    // Unpack the flat per-VC buses and classify each buffer head.
    always_comb begin
        for (int v = 0; v < VCN; v++) begin
            data_a[v]   = vc_data[v*DATA_W +: DATA_W];
            port_a[v]   = vc_port[v*PORTW +: PORTW];
            elig[v]     = vc_valid[v] & vc_head[v] & ({1'b0, port_a[v]} < PORT_LIM);
            bad_head[v] = vc_valid[v] & vc_head[v] & ({1'b0, port_a[v]} >= PORT_LIM);
        end
    end

    // Round-robin scan starting at rr_ptr, wrapping; the first eligible VC wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < VCN; i++) begin
            cand = VCHW'((32'(rr_ptr_q) + i) % VCN);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // A flit moves only when the granted port, the locked VC's buffer and the
    // downstream credit all line up in the same cycle.
    assign xfer = (state_q == S_ACTIVE) & grt[sel_port_q] & vc_valid[sel_vc_q] & cr_ok[sel_port_q];

    // State register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= S_IDLE;
            sel_vc_q   <= '0;
            sel_port_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            sel_vc_q   <= sel_vc_d;
            sel_port_q <= sel_port_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        sel_vc_d   = sel_vc_q;
        sel_port_d = sel_port_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_ACTIVE;
                    sel_vc_d   = win;
                    sel_port_d = port_a[win];
                end
            end
            S_ACTIVE: begin
                // Tail leaves: release the lock; the IDLE cycle that follows is
                // the mandatory gap before the next request.
                if (xfer && vc_tail[sel_vc_q]) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (32'(sel_vc_q) == VCN - 1) ? '0 : sel_vc_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: combinational pop strobe
    always_comb begin
        vc_deq = '0;
        if (xfer) begin
            vc_deq[sel_vc_q] = 1'b1;
        end
    end

    // Registered flit path and sticky error.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            idata_q  <= '0;
            ivalid_q <= 1'b0;
            ivch_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            ivalid_q <= xfer;
            if (xfer) begin
                idata_q <= data_a[sel_vc_q];
                ivch_q  <= sel_vc_q;
            end
            if (|bad_head) begin
                err_q <= 1'b1;
            end
        end
    end

    // req/port come straight from flops, so they are glitch-free.
    assign req    = (state_q == S_ACTIVE);
    assign port   = sel_port_q;
    assign idata  = idata_q;
    assign ivalid = ivalid_q;
    assign ivch   = ivch_q;
    assign err    = err_q;

endmodule
